treino_ctrl: RTL
================

Name: treino_ctrl

Overview:
- Epoch sequencer that sits directly upstream of the perceptron epoch stage (`epoca`). It owns the weight registers w0/w1/w2 (IEEE-754 half precision).
- Each epoch: presents the current weights to the stage, captures its 4 activations and the updated weights, then checks convergence against targets d.
- Repeats until all 4 samples are classified correctly, the epoch limit is hit, or the stage stops responding.

Parameters:
- MAX_EPOCHS, 16, epoch limit per run (1..2^EPW-1).
- EPW, 8, width of the epoch counter.
- TIMEOUT, 64, maximum cycles spent in WAIT before aborting (>=2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a training run.
- w0_init, w1_init, w2_init  in  16 each  initial weights (fp16), sampled on accepted start.
- d  in  4x16  packed target per sample, element i = sample i; fp16 1.0 (0x3C00) or 0.0 (0x0000); must be stable while busy.
- ep_start  out  1  one-cycle pulse launching an epoch in the stage.
- ep_w0, ep_w1, ep_w2  out  16 each  weights driven to the stage; stable from ep_start until ep_done.
- ep_done  in  1  stage reports an epoch complete; sampled only in WAIT.
- ep_result  in  4x16  activations y[i] of the completed epoch, valid with ep_done.
- ep_w0_new, ep_w1_new, ep_w2_new  in  16 each  updated weights, valid with ep_done.
- w0, w1, w2  out  16 each  committed weight registers.
- epochs  out  EPW  epochs completed in the current/last run.
- errors  out  3  mismatch count (0..4) of the last checked epoch.
- busy  out  1  high in ISSUE/WAIT/CHECK.
- done  out  1  sticky; set when a run ends, cleared on accepted start.
- converged  out  1  sticky; last run ended with errors==0.
- timeout  out  1  sticky; last run aborted in WAIT.

Behaviour:
- Reset (asynchronous, reset==0):
  - State IDLE.
  - w0/w1/w2, staging registers, epochs, errors and wait timer all 0.
  - ep_start, busy, done, converged, timeout all 0.
  - Reset mid-run aborts immediately; no partial state survives.
- ep_w* are continuously driven from w0/w1/w2.
- States and transitions:
  - IDLE: when start==1, load w*_init into w*; clear epochs, errors, done, converged, timeout; go to ISSUE. Otherwise start is ignored.
  - ISSUE: ep_start=1 for exactly this cycle; clear the wait timer; go to WAIT.
  - WAIT:
    - If ep_done==1: latch ep_result and ep_w*_new into staging; increment epochs; go to CHECK.
    - Else: increment the timer. When the timer reaches TIMEOUT-1 without ep_done, set timeout=1 and done=1, go to IDLE; weights are unchanged.
    - ep_done takes priority over timeout in the same cycle.
  - CHECK: errors = number of i with staged y[i] != d[i] (exact 16-bit compare).
    - errors==0: set converged=1 and done=1, go to IDLE. The staged weights are NOT committed; w* keeps the weights that classified correctly.
    - errors!=0: commit staged weights to w*. If epochs==MAX_EPOCHS, set done=1 with converged=0 and go to IDLE; otherwise go to ISSUE.
- Timing:
  - Accepted start at edge N gives ep_start high during cycle N+1.
  - Minimum epoch period is 3 cycles (ISSUE, WAIT with ep_done, CHECK).
  - Back-to-back ep_start pulses are therefore 3+k cycles apart, where k is the extra WAIT cycles.
- Ignored inputs:
  - start while busy is ignored; it neither restarts nor queues.
  - ep_done outside WAIT is ignored, including ep_done coincident with ep_start in ISSUE.
- Counters:
  - epochs never wraps: the limit check happens before the next ISSUE.
  - The timer saturates at TIMEOUT-1.
- No arithmetic is performed here; all fp16 math is done by the epoch stage. This block only compares bits.

Test Plan:
- OR dataset, d={0x3C00,0x3C00,0x3C00,0x0000} (i=3..0). Stage model returns 2 mismatches, then 1, then 0, with ep_done 2 cycles after ep_start → epochs=3, errors=0, converged=1, done=1. w* equals the weights staged at epoch 2; ep_start seen exactly 3 times.
- Initial weights w0=0xBC00, w1=w2=0x3C00; model returns y==d on the first epoch → epochs=1, converged=1, w*=init weights (new weights discarded).
- Model always returns 1 mismatch → run ends at epochs=16, converged=0, done=1, errors=1; w* equals the 16th staged weights.
- Model never asserts ep_done → timeout=1 and done=1 exactly TIMEOUT cycles after ep_start; w*=init weights; busy=0 afterwards.
- start pulsed again during WAIT, and ep_done pulsed in IDLE → no effect on state, epochs or ep_start count.
- reset driven low mid-WAIT (async, between edges) → all outputs 0 immediately. After release, a new start runs normally from epochs=0.

Source files
------------

// File: rtl/treino_ctrl.sv
// treino_ctrl: epoch sequencer for the perceptron training loop.
// Holds the committed fp16 weights, launches one epoch at a time in the
// downstream epoch stage, and stops once every sample is classified
// correctly, the epoch limit is reached, or the stage stops answering.
// Only bit comparisons are done here; all fp16 arithmetic lives in the stage.
module treino_ctrl #(
  parameter int MAX_EPOCHS = 16,
  parameter int EPW        = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           w0_init,
  input  logic [15:0]           w1_init,
  input  logic [15:0]           w2_init,
  input  logic [3:0][15:0]      d,
  output logic                  ep_start,
  output logic [15:0]           ep_w0,
  output logic [15:0]           ep_w1,
  output logic [15:0]           ep_w2,
  input  logic                  ep_done,
  input  logic [3:0][15:0]      ep_result,
  input  logic [15:0]           ep_w0_new,
  input  logic [15:0]           ep_w1_new,
  input  logic [15:0]           ep_w2_new,
  output logic [15:0]           w0,
  output logic [15:0]           w1,
  output logic [15:0]           w2,
  output logic [EPW-1:0]        epochs,
  output logic [2:0]            errors,
  output logic                  busy,
  output logic                  done,
  output logic                  converged,
  output logic                  timeout
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_CHECK = 2'd3
  } state_e;

  state_e           state_q;
  logic [15:0]      w0_q, w1_q, w2_q;
  logic [15:0]      stW0_q, stW1_q, stW2_q;
  logic [3:0][15:0] stY_q;
  logic [EPW-1:0]   epochs_q;
  logic [2:0]       errors_q;
  logic [TW-1:0]    timer_q;
  logic             epStart_q;
  logic             busy_q;
  logic             done_q;
  logic             converged_q;
  logic             timeout_q;
  logic [2:0]       errors_d;

  // Number of staged activations that differ bit-for-bit from their targets.
  always_comb begin
    errors_d = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (stY_q[i] != d[i]) begin
        errors_d = errors_d + 3'd1;
      end
    end
  end

  // Run sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      w0_q        <= 16'h0000;
      w1_q        <= 16'h0000;
      w2_q        <= 16'h0000;
      stW0_q      <= 16'h0000;
      stW1_q      <= 16'h0000;
      stW2_q      <= 16'h0000;
      stY_q       <= '0;
      epochs_q    <= '0;
      errors_q    <= 3'd0;
      timer_q     <= '0;
      epStart_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      converged_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      epStart_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            w0_q        <= w0_init;
            w1_q        <= w1_init;
            w2_q        <= w2_init;
            epochs_q    <= '0;
            errors_q    <= 3'd0;
            done_q      <= 1'b0;
            converged_q <= 1'b0;
            timeout_q   <= 1'b0;
            epStart_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (ep_done) begin
            stY_q    <= ep_result;
            stW0_q   <= ep_w0_new;
            stW1_q   <= ep_w1_new;
            stW2_q   <= ep_w2_new;
            epochs_q <= epochs_q + EPW'(1);
            state_q  <= S_CHECK;
          end else if (timer_q == TW'(TIMEOUT - 2)) begin
            timer_q   <= TW'(TIMEOUT - 1);
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_CHECK: begin
          errors_q <= errors_d;
          if (errors_d == 3'd0) begin
            // Keep the weights that just classified everything correctly.
            converged_q <= 1'b1;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            w0_q <= stW0_q;
            w1_q <= stW1_q;
            w2_q <= stW2_q;
            if (epochs_q == EPW'(MAX_EPOCHS)) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              epStart_q <= 1'b1;
              state_q   <= S_ISSUE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ep_start  = epStart_q;
  assign ep_w0     = w0_q;
  assign ep_w1     = w1_q;
  assign ep_w2     = w2_q;
  assign w0        = w0_q;
  assign w1        = w1_q;
  assign w2        = w2_q;
  assign epochs    = epochs_q;
  assign errors    = errors_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = converged_q;
  assign timeout   = timeout_q;

endmodule
